// File: rtl/keypad_if.sv
// Keypad decoder bundle: debounced row/column lines in, decoded key events out.
interface keypad_if;
  logic [4:0] row_in;
  logic [3:0] col_in;
  logic [4:0] key_code;
  logic       key_valid;
  logic       key_repeat;
  logic       key_held;
  logic       key_error;

  modport master (
    output row_in,
    output col_in,
    input  key_code,
    input  key_valid,
    input  key_repeat,
    input  key_held,
    input  key_error
  );

  modport slave (
    input  row_in,
    input  col_in,
    output key_code,
    output key_valid,
    output key_repeat,
    output key_held,
    output key_error
  );
endinterface

// File: rtl/keypad_decoder.sv
// 5x4 keypad decoder: confirms a single stable key press, emits press and
// auto-repeat pulses while held, and demands a confirmed release before the next key.
module keypad_decoder #(
  parameter int unsigned CONFIRM_CYCLES = 200000,
  parameter int unsigned REPEAT_DELAY   = 50000000,
  parameter int unsigned REPEAT_RATE    = 10000000
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.slave  kp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [31:0] CONFIRM_LAST = (CONFIRM_CYCLES > 32'd0) ? 32'(CONFIRM_CYCLES - 32'd1) : 32'd0;
  localparam logic [31:0] DELAY_LAST   = (REPEAT_DELAY > 32'd0)   ? 32'(REPEAT_DELAY - 32'd1)   : 32'd0;
  localparam logic [31:0] RATE_LAST    = (REPEAT_RATE > 32'd0)    ? 32'(REPEAT_RATE - 32'd1)    : 32'd0;

  function automatic logic [2:0] row_index(input logic [4:0] v);
    row_index = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (!v[i]) row_index = 3'(i);
    end
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] v);
    col_index = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) col_index = 2'(i);
    end
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [4:0]  row_r;
  logic [3:0]  col_r;
  state_t      state_r, state_n;
  logic [31:0] cnt_r, cnt_n;
  logic [31:0] rcnt_r, rcnt_n;
  logic        first_r, first_n;
  logic [4:0]  cand_r, cand_n;
  logic [4:0]  key_code_r, key_code_n;
  logic        key_valid_r, key_valid_n;
  logic        key_repeat_r, key_repeat_n;

  logic        idle_s, single_s, multi_s;
  logic [4:0]  code_s;
  logic [31:0] cnt_inc_s;
  logic [31:0] repeat_last_s;

  // Input capture register; decoding works only from these sampled lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_r <= 5'b11111;
      col_r <= 4'b1111;
    end else begin
      row_r <= kp.row_in;
      col_r <= kp.col_in;
    end
  end

  // Classify the sampled pattern; row*4+col is simply the concatenated indices.
  always_comb begin
    idle_s   = (row_r == 5'b11111) || (col_r == 4'b1111);
    single_s = $onehot(~row_r) && $onehot(~col_r);
    multi_s  = !idle_s && !single_s;
    code_s   = {row_index(row_r), col_index(col_r)};
  end

  // State and event registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= 32'd0;
      rcnt_r       <= 32'd0;
      first_r      <= 1'b0;
      cand_r       <= 5'd0;
      key_code_r   <= 5'd0;
      key_valid_r  <= 1'b0;
      key_repeat_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      cnt_r        <= cnt_n;
      rcnt_r       <= rcnt_n;
      first_r      <= first_n;
      cand_r       <= cand_n;
      key_code_r   <= key_code_n;
      key_valid_r  <= key_valid_n;
      key_repeat_r <= key_repeat_n;
    end
  end

  // Next-state logic. The IDLE->CONFIRM capture cycle counts as the first
  // stable clock, so acceptance lands CONFIRM_CYCLES clocks after the sample.
  always_comb begin
    state_n       = state_r;
    cnt_n         = cnt_r;
    rcnt_n        = rcnt_r;
    first_n       = first_r;
    cand_n        = cand_r;
    key_code_n    = key_code_r;
    key_valid_n   = 1'b0;
    key_repeat_n  = 1'b0;
    cnt_inc_s     = sat_inc(cnt_r);
    repeat_last_s = first_r ? DELAY_LAST : RATE_LAST;

    case (state_r)
      IDLE: begin
        if (single_s) begin
          state_n = CONFIRM;
          cand_n  = code_s;
          cnt_n   = 32'd0;
        end else begin
          state_n = IDLE;
        end
      end
      CONFIRM: begin
        if (single_s && (code_s == cand_r)) begin
          if (cnt_inc_s >= CONFIRM_LAST) begin
            state_n     = HELD;
            key_code_n  = cand_r;
            key_valid_n = 1'b1;
            cnt_n       = 32'd0;
            rcnt_n      = 32'd0;
            first_n     = 1'b1;
          end else begin
            cnt_n = cnt_inc_s;
          end
        end else begin
          state_n = IDLE;
          cnt_n   = 32'd0;
        end
      end
      HELD: begin
        if (idle_s) begin
          state_n = RELEASE;
          cnt_n   = 32'd0;
        end else if (single_s && (code_s == key_code_r)) begin
          // A due repeat right after another pulse waits one clock.
          if (rcnt_r >= repeat_last_s) begin
            if (!key_valid_r) begin
              key_valid_n  = 1'b1;
              key_repeat_n = 1'b1;
              rcnt_n       = 32'd0;
              first_n      = 1'b0;
            end else begin
              rcnt_n = rcnt_r;
            end
          end else begin
            rcnt_n = sat_inc(rcnt_r);
          end
        end else begin
          rcnt_n = rcnt_r;
        end
      end
      RELEASE: begin
        if (idle_s) begin
          if (cnt_inc_s >= CONFIRM_LAST) begin
            state_n = IDLE;
            cnt_n   = 32'd0;
          end else begin
            cnt_n = cnt_inc_s;
          end
        end else begin
          cnt_n = 32'd0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 32'd0;
        rcnt_n  = 32'd0;
      end
    endcase
  end

  assign kp.key_code   = key_code_r;
  assign kp.key_valid  = key_valid_r;
  assign kp.key_repeat = key_repeat_r;
  assign kp.key_held   = (state_r == HELD) || (state_r == RELEASE);
  assign kp.key_error  = multi_s;

endmodule
